// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg: shared FSM states, event-store depth and event record for btn_event_ctrl
package btn_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, QUALIFY = 2'd1, COMMIT = 2'd2} state_t;
  localparam int FIFO_DEPTH = 4;
  localparam int EVT_ID_W = 3;
  typedef struct packed {
    logic [EVT_ID_W-1:0] id;
    logic                press;
  } evt_t;
endpackage

// File: rtl/btn_event_ctrl_fifo.sv
// btn_evt_fifo: FIFO_DEPTH-entry event FIFO; a push on a full FIFO is accepted only when a pop happens in the same cycle
// Ports: clk, rst (async, active-high), push/din write side, pop = consumer ready,
//        dout/valid (not empty) read side, full = no free entry.
module btn_evt_fifo
  import btn_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  evt_t din,
  input  logic pop,
  output evt_t dout,
  output logic valid,
  output logic full
);
  localparam int PW = $clog2(FIFO_DEPTH);
  evt_t mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic wr, rd;
  assign valid = cnt != '0;
  assign full = cnt == (PW+1)'(FIFO_DEPTH);
  assign rd = valid && pop;
  assign wr = push && (!full || rd);
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + PW'(1);
      if (rd) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(wr) - (PW+1)'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: multi-button debouncer sharing one qualify counter, with a press/release event stream
// Ports: clk, rst (async, active-high); btn_raw bouncing inputs; btn_stable debounced levels;
//        press_pulse one-cycle rising-edge pulses; evt_valid/evt_ready/evt_id/evt_press event
//        handshake; evt_ovf sticky dropped-event flag.
// Build option: BTN_EVENT_FIFO_EN selects a 4-entry event FIFO instead of a single output register.
module btn_event_ctrl
  import btn_ctrl_pkg::*;
#(
  parameter int NUM_BTN = 5,
  parameter int DEBOUNCE_TIME = 1000000,
  parameter int CNT_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_BTN-1:0]         btn_raw,
  output logic [NUM_BTN-1:0]         btn_stable,
  output logic [NUM_BTN-1:0]         press_pulse,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [$clog2(NUM_BTN)-1:0] evt_id,
  output logic                       evt_press,
  output logic                       evt_ovf
);
  localparam int IDW = $clog2(NUM_BTN);
  localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_TIME);
  logic [NUM_BTN-1:0] s1, s2;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0] grant, last_grant, sel;
  logic found, enq, deq, st_full;
  evt_t ev_new, ev_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end
  // Round-robin search starting just after the last granted button.
  always_comb begin
    found = 1'b0;
    sel = '0;
    for (int k = 1; k <= NUM_BTN; k++)
      if (!found && s2[(int'(last_grant) + k) % NUM_BTN] != btn_stable[(int'(last_grant) + k) % NUM_BTN]) begin
        found = 1'b1;
        sel = IDW'((int'(last_grant) + k) % NUM_BTN);
      end
  end
  assign enq = state == COMMIT;
  assign deq = evt_valid && evt_ready;
  assign ev_new = '{id: EVT_ID_W'(grant), press: ~btn_stable[grant]};
  assign evt_id = ev_out.id[IDW-1:0];
  assign evt_press = ev_out.press;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      grant <= '0;
      last_grant <= IDW'(NUM_BTN - 1);
      btn_stable <= '0;
      press_pulse <= '0;
      evt_ovf <= 1'b0;
    end else begin
      press_pulse <= '0;
      if (enq && st_full && !deq) evt_ovf <= 1'b1;
      case (state)
        IDLE:
          if (found) begin
            cnt <= '0;
            grant <= sel;
            state <= QUALIFY;
          end
        QUALIFY:
          if (s2[grant] == btn_stable[grant]) begin
            cnt <= '0;
            last_grant <= grant;
            state <= IDLE;
          end else if (cnt < DB) cnt <= cnt + CNT_W'(1);
          else state <= COMMIT;
        COMMIT: begin
          btn_stable[grant] <= ~btn_stable[grant];
          press_pulse[grant] <= ~btn_stable[grant];
          last_grant <= grant;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef BTN_EVENT_FIFO_EN
  btn_evt_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(enq),
    .din(ev_new),
    .pop(evt_ready),
    .dout(ev_out),
    .valid(evt_valid),
    .full(st_full)
  );
`else
  // Single output register: it is full only while an event waits on a stalled consumer.
  assign st_full = evt_valid;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      ev_out <= '0;
    end else if (enq && !(evt_valid && !evt_ready)) begin
      evt_valid <= 1'b1;
      ev_out <= ev_new;
    end else if (deq) evt_valid <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb_btn_event_ctrl: directed and randomized checks of btn_event_ctrl against a behavioural model
module tb_btn_event_ctrl;
  localparam int N = 5;
  localparam int D = 4;
`ifdef BTN_EVENT_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_stable, press_pulse;
  logic evt_valid, evt_press, evt_ovf;
  logic evt_ready = 1'b1;
  logic [2:0] evt_id;
  int n_vec = 0;
  int n_err = 0;
  int got[$];
  int pulses[N];

  btn_event_ctrl #(.NUM_BTN(N), .DEBOUNCE_TIME(D), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_stable(btn_stable),
    .press_pulse(press_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_press(evt_press), .evt_ovf(evt_ovf)
  );

  always #5 clk = ~clk;

  // Events are logged as id*2+press when a transfer will happen at the next rising edge.
  always @(negedge clk)
    if (!rst) begin
      if (evt_valid && evt_ready) got.push_back(int'(evt_id) * 2 + int'(evt_press));
      for (int i = 0; i < N; i++) if (press_pulse[i]) pulses[i]++;
    end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    got.delete();
    for (int i = 0; i < N; i++) pulses[i] = 0;
  endtask

  task automatic test_reset();
    btn_raw = '0;
    evt_ready = 1'b1;
    rst = 1'b1;
    tick(2);
    n_vec++; if (btn_stable !== '0) begin n_err++; $display("FAIL reset_stable got %b want 00000", btn_stable); end
    n_vec++; if (press_pulse !== '0) begin n_err++; $display("FAIL reset_pulse got %b want 00000", press_pulse); end
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", evt_valid); end
    n_vec++; if (evt_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", evt_ovf); end
    do_reset();
  endtask

  task automatic test_clean_press();
    do_reset();
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    tick(8);
    n_vec++; if (btn_stable !== 5'b00000) begin n_err++; $display("FAIL press_early got %b want 00000", btn_stable); end
    tick(1);
    n_vec++; if (btn_stable !== 5'b00100) begin n_err++; $display("FAIL press_latency got %b want 00100", btn_stable); end
    n_vec++; if (press_pulse !== 5'b00100) begin n_err++; $display("FAIL press_pulse got %b want 00100", press_pulse); end
    n_vec++; if ({evt_valid, evt_id, evt_press} !== 5'b1_010_1) begin n_err++; $display("FAIL press_event got v%b id%0d p%b want v1 id2 p1", evt_valid, evt_id, evt_press); end
    tick(1);
    n_vec++; if (press_pulse !== 5'b00000) begin n_err++; $display("FAIL press_pulse_width got %b want 00000", press_pulse); end
    tick(3);
    n_vec++; if ({evt_valid, evt_id, evt_press} !== 5'b1_010_1) begin n_err++; $display("FAIL press_hold got v%b id%0d p%b want v1 id2 p1", evt_valid, evt_id, evt_press); end
    evt_ready = 1'b1;
    tick(1);
    n_vec++; if (evt_valid !== 1'b0) begin n_err++; $display("FAIL press_drain got %b want 0", evt_valid); end
    btn_raw[2] = 1'b0;
    tick(14);
    n_vec++; if (got.size() != 2 || got[0] != 5 || got[1] != 4) begin n_err++; $display("FAIL press_release_events got %p want '{5,4}", got); end
    n_vec++; if (btn_stable !== 5'b00000) begin n_err++; $display("FAIL release_stable got %b want 00000", btn_stable); end
  endtask

  task automatic test_bounce();
    do_reset();
    btn_raw[1] = 1'b1;
    tick(3);
    btn_raw[1] = 1'b0;
    tick(20);
    n_vec++; if (btn_stable !== 5'b00000) begin n_err++; $display("FAIL bounce_stable got %b want 00000", btn_stable); end
    n_vec++; if (got.size() != 0 || pulses[1] != 0) begin n_err++; $display("FAIL bounce_events got %0d events %0d pulses want 0 0", got.size(), pulses[1]); end
  endtask

  task automatic test_boundary();
    do_reset();
    btn_raw[3] = 1'b1;
    tick(D + 1);
    btn_raw[3] = 1'b0;
    tick(15);
    n_vec++; if (got.size() != 0 || btn_stable !== 5'b00000) begin n_err++; $display("FAIL short_pulse got %0d events stable %b want 0 00000", got.size(), btn_stable); end
    btn_raw[3] = 1'b1;
    tick(D + 2);
    btn_raw[3] = 1'b0;
    tick(25);
    n_vec++; if (got.size() != 2 || got[0] != 7 || got[1] != 6) begin n_err++; $display("FAIL min_pulse_events got %p want '{7,6}", got); end
    n_vec++; if (pulses[3] != 1 || btn_stable !== 5'b00000) begin n_err++; $display("FAIL min_pulse_state got %0d pulses stable %b want 1 00000", pulses[3], btn_stable); end
  endtask

  task automatic test_contention();
    do_reset();
    btn_raw = 5'b01001;
    tick(30);
    n_vec++; if (got.size() != 2 || got[0] != 1 || got[1] != 7) begin n_err++; $display("FAIL contention_order got %p want '{1,7}", got); end
    n_vec++; if (btn_stable !== 5'b01001) begin n_err++; $display("FAIL contention_stable got %b want 01001", btn_stable); end
    btn_raw = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    evt_ready = 1'b0;
    btn_raw = '1;
    tick(10);
    n_vec++; if (btn_stable !== 5'b00001 || evt_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_first got stable %b ovf %b want 00001 0", btn_stable, evt_ovf); end
    tick(50);
    n_vec++; if (btn_stable !== 5'b11111) begin n_err++; $display("FAIL ovf_stable got %b want 11111", btn_stable); end
    n_vec++; if (evt_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", evt_ovf); end
    n_vec++; if ({evt_valid, evt_id, evt_press} !== 5'b1_000_1) begin n_err++; $display("FAIL ovf_head got v%b id%0d p%b want v1 id0 p1", evt_valid, evt_id, evt_press); end
    evt_ready = 1'b1;
    tick(DEPTH + 2);
    n_vec++; if (got.size() != DEPTH) begin n_err++; $display("FAIL ovf_count got %0d want %0d", got.size(), DEPTH); end
    for (int k = 0; k < DEPTH && k < got.size(); k++) begin
      n_vec++; if (got[k] != k * 2 + 1) begin n_err++; $display("FAIL ovf_order[%0d] got %0d want %0d", k, got[k], k * 2 + 1); end
    end
    n_vec++; if (evt_ovf !== 1'b1 || evt_valid !== 1'b0) begin n_err++; $display("FAIL ovf_sticky got ovf %b valid %b want 1 0", evt_ovf, evt_valid); end
    btn_raw = '0;
    do_reset();
    n_vec++; if (evt_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", evt_ovf); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_raw[4] = 1'b1;
    tick(5);
    rst = 1'b1;
    #1;
    n_vec++; if ({btn_stable, press_pulse, evt_valid, evt_ovf} !== '0) begin n_err++; $display("FAIL mid_reset got %b %b %b %b want all 0", btn_stable, press_pulse, evt_valid, evt_ovf); end
    tick(1);
    rst = 1'b0;
    got.delete();
    tick(20);
    n_vec++; if (got.size() != 1 || got[0] != 9) begin n_err++; $display("FAIL mid_requalify got %p want '{9}", got); end
    n_vec++; if (btn_stable !== 5'b10000) begin n_err++; $display("FAIL mid_stable got %b want 10000", btn_stable); end
    btn_raw = '0;
  endtask

  // Model: a level change held for good commits one event; a pulse shorter than D+2 cycles is ignored.
  task automatic test_random();
    logic [N-1:0] level;
    int exp_ev[$];
    int exp_pulses[N];
    int b, len;
    do_reset();
    btn_raw = '0;
    evt_ready = 1'b1;
    level = '0;
    for (int i = 0; i < N; i++) exp_pulses[i] = 0;
    for (int it = 0; it < 40; it++) begin
      b = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) == 0) begin
        len = int'($urandom_range(1, D + 1));
        btn_raw[b] = ~btn_raw[b];
        tick(len);
        btn_raw[b] = ~btn_raw[b];
      end else begin
        btn_raw[b] = ~btn_raw[b];
        level[b] = ~level[b];
        exp_ev.push_back(b * 2 + int'(level[b]));
        if (level[b]) exp_pulses[b]++;
      end
      tick(16);
      n_vec++; if (btn_stable !== level) begin n_err++; $display("FAIL rand_stable[%0d] got %b want %b", it, btn_stable, level); end
    end
    n_vec++; if (got.size() != exp_ev.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", got.size(), exp_ev.size()); end
    for (int k = 0; k < exp_ev.size() && k < got.size(); k++) begin
      n_vec++; if (got[k] != exp_ev[k]) begin n_err++; $display("FAIL rand_event[%0d] got %0d want %0d", k, got[k], exp_ev[k]); end
    end
    for (int i = 0; i < N; i++) begin
      n_vec++; if (pulses[i] != exp_pulses[i]) begin n_err++; $display("FAIL rand_pulses[%0d] got %0d want %0d", i, pulses[i], exp_pulses[i]); end
    end
    n_vec++; if (evt_ovf !== 1'b0) begin n_err++; $display("FAIL rand_ovf got %b want 0", evt_ovf); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_boundary();
    test_contention();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameter NUM_BTN, default 5: number of button inputs (range 2..8).
REQ-002 SHALL have parameter DEBOUNCE_TIME, default 1000000: qualify cycles per edge.
REQ-003 SHALL have parameter CNT_W, default 20: shared counter width; DEBOUNCE_TIME SHALL be less than 2^CNT_W.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port btn_raw, input, NUM_BTN bits: asynchronous bouncing button inputs.
REQ-007 SHALL have port btn_stable, output, NUM_BTN bits: debounced button levels.
REQ-008 SHALL have port press_pulse, output, NUM_BTN bits: one-cycle pulse on a committed 0->1 edge.
REQ-009 SHALL have port evt_valid, output, 1 bit: an event is presented on evt_id and evt_press.
REQ-010 SHALL have port evt_ready, input, 1 bit: consumer accepts the presented event.
REQ-011 SHALL have port evt_id, output, clog2(NUM_BTN) bits: index of the button that changed.
REQ-012 SHALL have port evt_press, output, 1 bit: 1 for a press, 0 for a release.
REQ-013 SHALL have port evt_ovf, output, 1 bit: sticky flag, set when an event is dropped.

Function
REQ-014 SHALL pass each btn_raw bit through a 2-flop synchronizer; the result is sync[i].
REQ-015 SHALL share one CNT_W-bit counter among all buttons, with at most one button qualifying at a time.
REQ-016 SHALL use FSM states IDLE, QUALIFY and COMMIT.
REQ-017 In IDLE, SHALL grant the first i with sync[i] != btn_stable[i], searching round-robin from last_grant+1 modulo NUM_BTN; on a grant SHALL clear the counter, record grant = i and enter QUALIFY.
REQ-018 In QUALIFY with sync[grant] != btn_stable[grant] and counter < DEBOUNCE_TIME, SHALL increment the counter.
REQ-019 In QUALIFY with sync[grant] == btn_stable[grant], SHALL abort: clear the counter, set last_grant = grant and go to IDLE, with no output change.
REQ-020 In QUALIFY with the mismatch still present and counter == DEBOUNCE_TIME, SHALL go to COMMIT.
REQ-021 COMMIT SHALL last one cycle and do all of the following: toggle btn_stable[grant], assert press_pulse[grant] when the new level is 1, enqueue event {grant, new level}, set last_grant = grant, go to IDLE.
REQ-022 Latency: btn_stable SHALL update exactly DEBOUNCE_TIME+2 cycles after the grant cycle, not counting the synchronizer.
REQ-023 Changes on non-granted buttons during a qualification SHALL wait; no edge is lost while the mismatch persists.
REQ-024 Event handshake: the transfer occurs on a cycle with evt_valid && evt_ready; evt_id and evt_press SHALL hold stable while evt_valid && !evt_ready.
REQ-025 When an enqueue meets a full event store, SHALL drop the new event, set evt_ovf, and still update btn_stable and press_pulse.
REQ-026 When an enqueue and a dequeue occur in the same cycle on a full store, SHALL accept the new event with no overflow.

Reset
REQ-027 On rst, SHALL asynchronously clear btn_stable, press_pulse, evt_valid, evt_ovf, the counter, the synchronizers and the event store; SHALL set the state to IDLE and last_grant = NUM_BTN-1.
REQ-028 A reset mid-QUALIFY or mid-COMMIT SHALL discard the pending edge; after reset, buttons held high SHALL requalify from IDLE.
REQ-029 evt_ovf SHALL clear only on rst.

Configuration
REQ-030 With BTN_EVENT_FIFO_EN defined, the event store SHALL be a 4-entry FIFO in which evt_valid means not empty.
REQ-031 Without BTN_EVENT_FIFO_EN, the event store SHALL be a single output register; full means evt_valid && !evt_ready.

Structure
REQ-032 Package btn_ctrl_pkg SHALL hold the FSM state enum, the FIFO depth constant (4) and the event struct {id, press}.
REQ-033 The FIFO SHALL be sub-module btn_evt_fifo, instantiated only under BTN_EVENT_FIFO_EN.

Verification (NUM_BTN=5, DEBOUNCE_TIME=4)
REQ-034 Clean press: btn_raw[2] goes 0->1 and holds -> btn_stable[2]=1 at grant+6, press_pulse[2] high for 1 cycle, event {id=2, press=1}.
REQ-035 Bounce: btn_raw[1] high for 3 cycles, then low -> abort, no event, btn_stable unchanged.
REQ-036 Contention: btn_raw[0] and btn_raw[3] rise in the same cycle after reset -> button 0 commits first, then button 3; two events in that order.
REQ-037 Overflow, with the macro undefined and evt_ready=0: two commits -> first event held, second dropped, evt_ovf=1, btn_stable shows both changes.
REQ-038 Reset mid-QUALIFY: rst pulsed at counter=2 -> all outputs 0, state IDLE, no event.
REQ-039 FIFO, with the macro defined and evt_ready=0: five commits -> four events retained in order, evt_ovf=1.
